// File: rtl/fp_align_stage.sv
// Operand-alignment stage of the FP adder: unpacks two IEEE-754 words, orders them by magnitude
// and right-shifts the smaller mantissa by the exponent difference with guard/round/sticky bits.
module fp_align_stage #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W  = 1 + EXP_W + MAN_W,
    localparam int MW = MAN_W + 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign_big,
    output logic [EXP_W-1:0] out_exp,
    output logic [MW-1:0]    out_man_big,
    output logic [MW-1:0]    out_man_small,
    output logic             out_eff_sub,
    output logic             out_swap,
    output logic             out_nan,
    output logic             out_inf
);

    typedef struct packed {
        logic             sign_big;
        logic [EXP_W-1:0] exp_big;
        logic [MW-1:0]    man_big;
        logic [MAN_W:0]   man_small;
        logic [EXP_W-1:0] diff;
        logic             eff_sub;
        logic             swap;
        logic             nan;
        logic             inf;
    } s1_t;

    logic             s1_valid, s2_valid, advance;
    s1_t              s1, s1_nxt;

    logic [EXP_W-1:0] ea, eb, eea, eeb;
    logic [MAN_W-1:0] fa, fb;
    logic             ha, hb, a_max, b_max, a_nan, b_nan, a_inf, b_inf, b_gt, eff_sub;

    assign ea = a[W-2 -: EXP_W];
    assign eb = b[W-2 -: EXP_W];
    assign fa = a[MAN_W-1:0];
    assign fb = b[MAN_W-1:0];
    assign ha = |ea;
    assign hb = |eb;
    assign eea = ha ? ea : EXP_W'(1);
    assign eeb = hb ? eb : EXP_W'(1);

    assign a_max = &ea;
    assign b_max = &eb;
    assign a_nan = a_max && (fa != '0);
    assign b_nan = b_max && (fb != '0);
    assign a_inf = a_max && (fa == '0);
    assign b_inf = b_max && (fb == '0);
    assign eff_sub = a[W-1] ^ b[W-1];

    // Hidden bit breaks the eff_exp==1 tie between a denormal and the smallest normals.
    assign b_gt = {eeb, hb, fb} > {eea, ha, fa};

    always_comb begin
        s1_nxt = '0;
        s1_nxt.swap    = b_gt;
        s1_nxt.eff_sub = eff_sub;
        s1_nxt.nan     = a_nan || b_nan || (a_inf && b_inf && eff_sub);
        s1_nxt.inf     = (a_inf || b_inf) && !s1_nxt.nan;
        if (b_gt) begin
            s1_nxt.sign_big  = b[W-1];
            s1_nxt.exp_big   = eeb;
            s1_nxt.man_big   = {hb, fb, 3'b000};
            s1_nxt.man_small = {ha, fa};
            s1_nxt.diff      = eeb - eea;
        end else begin
            s1_nxt.sign_big  = a[W-1];
            s1_nxt.exp_big   = eea;
            s1_nxt.man_big   = {ha, fa, 3'b000};
            s1_nxt.man_small = {hb, fb};
            s1_nxt.diff      = eea - eeb;
        end
    end

    // Shift into a double-width window; the lower half collects everything shifted out.
    logic [2*MW-1:0] ext;
    logic [MW-1:0]   small_al;

    assign ext = {s1.man_small, 3'b000, {MW{1'b0}}} >> s1.diff;

    always_comb begin
        small_al = '0;
        if (32'(s1.diff) >= MW)
            small_al = {{(MW-1){1'b0}}, |s1.man_small};
        else
            small_al = ext[2*MW-1:MW] | {{(MW-1){1'b0}}, |ext[MW-1:0]};
    end

    assign advance   = !s2_valid || out_ready;
    assign in_ready  = reset_n && (!s1_valid || advance);
    assign out_valid = s2_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) s1 <= s1_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid      <= 1'b0;
            out_sign_big  <= 1'b0;
            out_exp       <= '0;
            out_man_big   <= '0;
            out_man_small <= '0;
            out_eff_sub   <= 1'b0;
            out_swap      <= 1'b0;
            out_nan       <= 1'b0;
            out_inf       <= 1'b0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_sign_big  <= s1.sign_big;
                out_exp       <= s1.exp_big;
                out_man_big   <= s1.man_big;
                out_man_small <= small_al;
                out_eff_sub   <= s1.eff_sub;
                out_swap      <= s1.swap;
                out_nan       <= s1.nan;
                out_inf       <= s1.inf;
            end
        end
    end

endmodule

// File: tb/tb_fp_align_stage.sv
// Directed-vector bench for fp_align_stage: alignment values, special cases, stall and reset.
module tb_fp_align_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b;
    logic        out_sign_big, out_eff_sub, out_swap, out_nan, out_inf;
    logic [7:0]  out_exp;
    logic [26:0] out_man_big, out_man_small;

    int n_vec = 0;
    int n_err = 0;

    fp_align_stage #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign_big(out_sign_big), .out_exp(out_exp),
        .out_man_big(out_man_big), .out_man_small(out_man_small),
        .out_eff_sub(out_eff_sub), .out_swap(out_swap),
        .out_nan(out_nan), .out_inf(out_inf)
    );

    always #5 clk = ~clk;

    // Present one pair for a single accept edge; returns at the negedge where it is on the output.
    task automatic push(input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk); a = va; b = vb; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        repeat (2) @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_vec++; if ({out_exp, out_man_big, out_man_small, out_nan, out_inf, out_swap} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got %h %h %h want 0", out_exp, out_man_big, out_man_small); end
        reset_n = 1'b1;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic;
        @(negedge clk); a = 32'h3F800000; b = 32'h3F800000; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL latency_early: got %b want 0", out_valid); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL latency_valid: got %b want 1", out_valid); end
        n_vec++; if (out_exp !== 8'h7F) begin n_err++; $display("FAIL basic_exp: got %h want 7f", out_exp); end
        n_vec++; if (out_man_big !== 27'h4000000 || out_man_small !== 27'h4000000) begin
            n_err++; $display("FAIL basic_man: got %h %h want 4000000 4000000", out_man_big, out_man_small); end
        n_vec++; if ({out_eff_sub, out_swap} !== 2'b00) begin n_err++; $display("FAIL basic_flags: got %b want 00", {out_eff_sub, out_swap}); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_swap;
        push(32'h3F000000, 32'h40000000);
        n_vec++; if (out_swap !== 1'b1) begin n_err++; $display("FAIL swap_flag: got %b want 1", out_swap); end
        n_vec++; if (out_exp !== 8'h80) begin n_err++; $display("FAIL swap_exp: got %h want 80", out_exp); end
        n_vec++; if (out_man_big !== 27'h4000000 || out_man_small !== 27'h1000000) begin
            n_err++; $display("FAIL swap_man: got %h %h want 4000000 1000000", out_man_big, out_man_small); end
        // Equal magnitude, opposite signs: tie keeps A as big.
        push(32'h3F800000, 32'hBF800000);
        n_vec++; if ({out_eff_sub, out_swap, out_sign_big} !== 3'b100) begin
            n_err++; $display("FAIL tie_flags: got %b want 100", {out_eff_sub, out_swap, out_sign_big}); end
        push(32'hC0000000, 32'h3F800000);
        n_vec++; if ({out_sign_big, out_swap, out_man_small} !== {2'b10, 27'h2000000}) begin
            n_err++; $display("FAIL neg_big: got %b %b %h want 1 0 2000000", out_sign_big, out_swap, out_man_small); end
    endtask

    task automatic test_sticky;
        push(32'h4B800000, 32'h3F800001);
        n_vec++; if (out_man_small !== 27'h0000005) begin n_err++; $display("FAIL sticky_d24: got %h want 0000005", out_man_small); end
        n_vec++; if (out_exp !== 8'h97) begin n_err++; $display("FAIL sticky_exp: got %h want 97", out_exp); end
        push(32'h4F800000, 32'h3F800000);
        n_vec++; if (out_man_small !== 27'h0000001) begin n_err++; $display("FAIL sticky_d32: got %h want 0000001", out_man_small); end
        // Two denormals: eff_exp 1, hidden 0, diff 0.
        push(32'h00000001, 32'h00000000);
        n_vec++; if ({out_exp, out_man_big, out_man_small} !== {8'h01, 27'h0000008, 27'h0}) begin
            n_err++; $display("FAIL denorm: got %h %h %h want 01 0000008 0000000", out_exp, out_man_big, out_man_small); end
    endtask

    task automatic test_special;
        push(32'h7F800000, 32'hFF800000);
        n_vec++; if ({out_nan, out_inf} !== 2'b10) begin n_err++; $display("FAIL inf_minus_inf: got %b want 10", {out_nan, out_inf}); end
        push(32'h7F800000, 32'h3F800000);
        n_vec++; if ({out_nan, out_inf, out_exp} !== {2'b01, 8'hFF}) begin
            n_err++; $display("FAIL inf_plus_one: got %b %h want 01 ff", {out_nan, out_inf}, out_exp); end
        push(32'h7FC00000, 32'h3F800000);
        n_vec++; if ({out_nan, out_inf} !== 2'b10) begin n_err++; $display("FAIL nan_in: got %b want 10", {out_nan, out_inf}); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk); a = 32'h3F800000; b = 32'h3F800000; in_valid = 1'b1;
        @(negedge clk); a = 32'h40000000; b = 32'h40000000;
        @(negedge clk); a = 32'h40800000; b = 32'h40800000;
        n_vec++; if (out_valid !== 1'b1 || out_exp !== 8'h7F) begin n_err++; $display("FAIL b2b_first: got %b %h want 1 7f", out_valid, out_exp); end
        @(negedge clk); in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1 || out_exp !== 8'h80) begin n_err++; $display("FAIL b2b_second: got %b %h want 1 80", out_valid, out_exp); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || out_exp !== 8'h81) begin n_err++; $display("FAIL b2b_third: got %b %h want 1 81", out_valid, out_exp); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_stall;
        out_ready = 1'b0;
        @(negedge clk); a = 32'h3F800000; b = 32'h3F800000; in_valid = 1'b1;
        @(negedge clk); a = 32'h40000000; b = 32'h40000000;
        @(negedge clk); a = 32'h40800000; b = 32'h40800000;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
        repeat (3) begin
            @(negedge clk);
            n_vec++; if (out_valid !== 1'b1 || out_exp !== 8'h7F || out_man_small !== 27'h4000000) begin
                n_err++; $display("FAIL stall_hold: got %b %h %h want 1 7f 4000000", out_valid, out_exp, out_man_small); end
        end
        out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
        @(negedge clk); in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1 || out_exp !== 8'h80) begin n_err++; $display("FAIL stall_second: got %b %h want 1 80", out_valid, out_exp); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || out_exp !== 8'h81) begin n_err++; $display("FAIL stall_third: got %b %h want 1 81", out_valid, out_exp); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_mid_reset;
        out_ready = 1'b0;
        @(negedge clk); a = 32'h3F800000; b = 32'h3F800000; in_valid = 1'b1;
        @(negedge clk); a = 32'h40000000; b = 32'h40000000;
        @(negedge clk); in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_loaded: got %b want 1", out_valid); end
        #2 reset_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL mid_reset_async: got valid %b ready %b want 0 0", out_valid, in_ready); end
        n_vec++; if (out_exp !== 8'h00 || out_man_big !== 27'h0) begin
            n_err++; $display("FAIL mid_reset_data: got %h %h want 00 0000000", out_exp, out_man_big); end
        @(negedge clk); reset_n = 1'b1; out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale: got %b want 0", out_valid); end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_swap;
        test_sticky;
        test_special;
        test_back_to_back;
        test_stall;
        test_mid_reset;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
